// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl: session controller for a Galois-LFSR XOR stream cipher.
// It handles seed/tap config and warm-up discard, then XORs each byte with 8 serially generated keystream bits.
module xor_cipher_ctrl #(
  parameter int          WARMUP       = 64,
  parameter logic [31:0] DEFAULT_SEED = 32'h55,
  parameter logic [31:0] DEFAULT_TAPS = 32'h80200003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_load,
  input  logic [31:0] cfg_seed,
  input  logic [31:0] cfg_taps,
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy,
  output logic [15:0] byte_count
);
  typedef enum logic [2:0] {ST_IDLE, ST_WARM, ST_ACCEPT, ST_GEN, ST_OUT} state_t;
  state_t      state_q, state_d;
  logic [31:0] seed_q, seed_d, taps_q, taps_d, lfsr_q, lfsr_d, cnt_q, cnt_d;
  logic [31:0] lfsr_step, new_seed;
  logic [2:0]  bit_q, bit_d;
  logic [6:0]  ks_q, ks_d;
  logic [7:0]  data_q, data_d, m_data_q, m_data_d;
  logic [15:0] count_q, count_d;
  logic        m_valid_q, m_valid_d, stop_pend_q, stop_pend_d;
  assign lfsr_step = lfsr_q[0] ? (lfsr_q >> 1) ^ taps_q : lfsr_q >> 1;
  assign new_seed  = (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    taps_d      = taps_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    ks_d        = ks_q;
    data_d      = data_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        seed_d = cfg_load ? new_seed : seed_q;
        taps_d = cfg_load ? cfg_taps : taps_q;
        if (start) begin
          lfsr_d  = cfg_load ? new_seed : seed_q;
          count_d = '0;
          cnt_d   = '0;
          state_d = (WARMUP == 0) ? ST_ACCEPT : ST_WARM;
        end
      end
      ST_WARM: begin
        lfsr_d  = lfsr_step;
        cnt_d   = cnt_q + 32'd1;
        state_d = stop ? ST_IDLE : (cnt_q + 32'd1 == 32'(WARMUP)) ? ST_ACCEPT : ST_WARM;
      end
      ST_ACCEPT: begin
        if (stop) state_d = ST_IDLE;
        else if (s_valid) begin
          data_d  = s_data;
          bit_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        // keystream bits shift in at the top so bit 0 lands at ks_q[0] after 7 steps
        lfsr_d      = lfsr_step;
        ks_d        = {lfsr_q[0], ks_q[6:1]};
        bit_d       = bit_q + 3'd1;
        stop_pend_d = stop_pend_q | stop;
        if (bit_q == 3'd7) begin
          m_data_d  = data_q ^ {lfsr_q[0], ks_q};
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        stop_pend_d = stop_pend_q | stop;
        if (m_ready) begin
          m_valid_d = 1'b0;
          count_d   = count_q + 16'd1;
          state_d   = (stop_pend_q | stop) ? ST_IDLE : ST_ACCEPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= DEFAULT_SEED;
      taps_q      <= DEFAULT_TAPS;
      lfsr_q      <= DEFAULT_SEED;
      cnt_q       <= '0;
      bit_q       <= '0;
      ks_q        <= '0;
      data_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      taps_q      <= taps_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      ks_q        <= ks_d;
      data_q      <= data_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
    end
  end
  assign s_ready    = (state_q == ST_ACCEPT);
  assign busy       = (state_q != ST_IDLE);
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign byte_count = count_q;
endmodule
